// File: rtl/nios_nios2_qsys_0_oci_dct_packer.sv
// DCT packer: gathers 2-bit trace fragments into a 30-bit word and emits it
// when full or flushed, then sequences the end-of-test handshake.
module nios_nios2_qsys_0_oci_dct_packer #(
    parameter int EMIT_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frag_valid,
    input  logic [1:0]            frag_data,
    input  logic                  flush,
    input  logic                  end_req,
    output logic [29:0]           dct_buffer,
    output logic [3:0]            dct_count,
    output logic                  dct_valid,
    output logic                  test_ending,
    output logic                  test_has_ended,
    output logic                  frag_dropped,
    output logic [EMIT_CNT_W-1:0] emit_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENDING = 2'd1,
        ENDED  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [29:0] acc, nxt;
    logic [3:0]  acc_cnt, nxt_cnt;
    logic        emit, do_emit, ending_nxt, ended_nxt, dropped_nxt;

    // Accumulator view including this cycle's fragment; slots above acc_cnt
    // are always zero, so OR-ing the fragment in is enough.
    always_comb begin
        nxt     = acc;
        nxt_cnt = acc_cnt + {3'b000, frag_valid};
        if (frag_valid)
            nxt = acc | (30'(frag_data) << {acc_cnt, 1'b0});
        emit = (nxt_cnt == 4'd15) || ((flush || end_req) && (nxt_cnt != 4'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (end_req) state_nxt = ENDING;
            ENDING:  state_nxt = ENDED;
            ENDED:   state_nxt = ENDED;
            default: state_nxt = RUN;
        endcase
    end

    // Next values of the registered outputs; outside RUN the packer is inert.
    always_comb begin
        do_emit     = (state == RUN) && emit;
        ending_nxt  = (state == ENDING);
        ended_nxt   = (state == ENDED);
        dropped_nxt = frag_dropped || ((state != RUN) && frag_valid);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= '0;
            acc_cnt        <= '0;
            dct_buffer     <= '0;
            dct_count      <= '0;
            dct_valid      <= 1'b0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
            frag_dropped   <= 1'b0;
            emit_count     <= '0;
        end else begin
            dct_valid      <= do_emit;
            test_ending    <= ending_nxt;
            test_has_ended <= ended_nxt;
            frag_dropped   <= dropped_nxt;
            if (do_emit) begin
                dct_buffer <= nxt;
                dct_count  <= nxt_cnt;
                emit_count <= emit_count + 1'b1;
                acc        <= '0;
                acc_cnt    <= '0;
            end else if (state == RUN) begin
                acc        <= nxt;
                acc_cnt    <= nxt_cnt;
            end
        end
    end

endmodule

// File: tb/tb_nios_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the DCT packer: directed test-plan cases followed by
// randomized traffic compared every cycle against a queue-based model.
module tb_nios_nios2_qsys_0_oci_dct_packer;

    localparam int W = 4;  // narrow counter so wrap-around occurs quickly

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         frag_valid = 1'b0;
    logic [1:0]   frag_data = 2'b00;
    logic         flush = 1'b0;
    logic         end_req = 1'b0;
    logic [29:0]  dct_buffer;
    logic [3:0]   dct_count;
    logic         dct_valid, test_ending, test_has_ended, frag_dropped;
    logic [W-1:0] emit_count;

    int checks = 0;
    int failures = 0;

    // Reference model: pending fragments kept as a queue, phase 0/1/2.
    int          pend[$];
    int          phase = 0;
    logic [29:0] m_buf = '0;
    int          m_cnt = 0;
    logic        m_valid = 0, m_ending = 0, m_ended = 0, m_dropped = 0;
    int          m_emits = 0;

    nios_nios2_qsys_0_oci_dct_packer #(.EMIT_CNT_W(W)) dut (
        .clk(clk), .reset(reset), .frag_valid(frag_valid), .frag_data(frag_data),
        .flush(flush), .end_req(end_req), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .dct_valid(dct_valid), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .frag_dropped(frag_dropped),
        .emit_count(emit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, fv, input logic [1:0] fd, input logic fl, er);
        longint word;
        if (rst) begin
            pend.delete();
            phase = 0; m_buf = '0; m_cnt = 0; m_valid = 0;
            m_ending = 0; m_ended = 0; m_dropped = 0; m_emits = 0;
            return;
        end
        m_valid = 0;
        m_ending = 0;
        case (phase)
            0: begin
                if (fv) pend.push_back(int'(fd));
                if (pend.size() == 15 || ((fl || er) && pend.size() > 0)) begin
                    word = 0;
                    foreach (pend[k]) word += longint'(pend[k]) * (longint'(1) << (2 * k));
                    m_buf = word[29:0];
                    m_cnt = pend.size();
                    m_valid = 1;
                    m_emits = (m_emits + 1) % (1 << W);
                    pend.delete();
                end
                if (er) phase = 1;
            end
            1: begin
                if (fv) m_dropped = 1;
                m_ending = 1;
                phase = 2;
            end
            default: begin
                if (fv) m_dropped = 1;
                m_ended = 1;
            end
        endcase
    endtask

    task automatic compare_all();
        check("valid", dct_valid, m_valid);
        if (m_valid || m_cnt != 0) begin
            check("buffer", dct_buffer, m_buf);
            check("count", dct_count, m_cnt);
        end
        check("ending", test_ending, m_ending);
        check("has_ended", test_has_ended, m_ended);
        check("dropped", frag_dropped, m_dropped);
        check("emit_count", emit_count, m_emits);
    endtask

    task automatic cycle(input logic rst, fv, input logic [1:0] fd, input logic fl, er);
        reset = rst; frag_valid = fv; frag_data = fd; flush = fl; end_req = er;
        @(posedge clk);
        model_step(rst, fv, fd, fl, er);
        #1;
        compare_all();
    endtask

    task automatic frag(input logic [1:0] fd);
        cycle(0, 1, fd, 0, 0);
    endtask

    task automatic idle();
        cycle(0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("rst_buffer", dct_buffer, 0);
        check("rst_count", dct_count, 0);
        check("rst_valid", dct_valid, 0);

        // 15 fragments k mod 4 fill a word
        for (int k = 0; k < 15; k++) frag(2'(k % 4));
        check("full_valid", dct_valid, 1);
        check("full_count", dct_count, 15);
        check("full_buffer", dct_buffer, 32'h24E4E4E4);
        check("full_emits", emit_count, 1);
        idle();

        // partial word by flush, then an empty flush
        frag(2'd1); frag(2'd2); frag(2'd3);
        cycle(0, 0, 0, 1, 0);
        check("flush_count", dct_count, 3);
        check("flush_buffer", dct_buffer, 32'h39);
        cycle(0, 0, 0, 1, 0);
        check("empty_flush", dct_valid, 0);

        // 16 consecutive fragments: 15 emitted, one carried over
        for (int k = 0; k < 15; k++) frag(2'($urandom));
        check("sixteen_valid", dct_valid, 1);
        check("sixteen_count", dct_count, 15);
        frag(2'd2);
        check("carry_no_emit", dct_valid, 0);
        cycle(0, 0, 0, 1, 0);
        check("carry_count", dct_count, 1);
        check("carry_buffer", dct_buffer, 32'h2);

        // end sequence with a coincident fragment
        for (int k = 0; k < 5; k++) frag(2'd3);
        cycle(0, 1, 2'd3, 0, 1);
        check("end_valid", dct_valid, 1);
        check("end_count", dct_count, 6);
        check("end_buffer", dct_buffer, 32'hFFF);
        idle();
        check("ending_pulse", test_ending, 1);
        check("ending_no_ended", test_has_ended, 0);
        idle();
        check("ending_done", test_ending, 0);
        check("ended_high", test_has_ended, 1);
        cycle(0, 1, 2'd1, 1, 1);
        check("drop_flag", frag_dropped, 1);
        check("drop_no_valid", dct_valid, 0);
        idle();
        check("ended_hold", test_has_ended, 1);

        // reset from ENDED clears everything
        cycle(1, 0, 0, 0, 0);
        check("rst_ended", test_has_ended, 0);
        check("rst_dropped", frag_dropped, 0);
        check("rst_emits", emit_count, 0);
        check("rst_count2", dct_count, 0);

        // reset mid-accumulation discards stale fragments
        for (int k = 0; k < 7; k++) frag(2'd1);
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++) frag(2'd2);
        check("stale_no_emit", dct_valid, 0);
        frag(2'd2);
        check("stale_count", dct_count, 15);
        check("stale_buffer", dct_buffer, 32'h2AAAAAAA);
        check("stale_emits", emit_count, 1);

        // randomized traffic, compared every cycle
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 249) == 0, ($urandom % 4) != 0, 2'($urandom),
                  ($urandom % 8) == 0, $urandom_range(0, 149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_nios2_qsys_0_oci_dct_packer.md
# nios_nios2_qsys_0_oci_dct_packer

Data-compression-trace (DCT) packer for the Nios II OCI trace path. It collects 2-bit trace fragments into a 30-bit buffer and emits the buffer with a fragment count when it is full or flushed. It also sequences the end-of-test handshake. It sits directly upstream of the OCI test bench and drives that block's `dct_buffer`, `dct_count`, `test_ending` and `test_has_ended` inputs.

## Interface

- `EMIT_CNT_W`, default 16: width of the emitted-word counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `frag_valid`  in  1  a trace fragment is presented this cycle.
- `frag_data`  in  2  trace fragment payload.
- `flush`  in  1  emit the partial buffer this cycle.
- `end_req`  in  1  begin the end-of-test sequence. Sampled in RUN only.
- `dct_buffer`  out  30  packed fragments. Fragment k is at bits [2k+1:2k]; unused high bits are 0.
- `dct_count`  out  4  number of valid fragments in `dct_buffer`, 1..15.
- `dct_valid`  out  1  one-cycle strobe qualifying `dct_buffer` and `dct_count`.
- `test_ending`  out  1  one-cycle strobe marking the end of trace.
- `test_has_ended`  out  1  held high after end of trace until reset.
- `frag_dropped`  out  1  sticky; a fragment arrived after RUN.
- `emit_count`  out  EMIT_CNT_W  number of `dct_valid` strobes since reset; wraps.

## Operation

- Internal accumulator `acc[29:0]` and `acc_cnt[3:0]`.
- Per cycle in RUN, form the next value:
  - `nxt` = `acc` with `frag_data` written at slot `acc_cnt`, when `frag_valid`; otherwise `acc`.
  - `nxt_cnt` = `acc_cnt + frag_valid`.
- Emit condition: `nxt_cnt == 15`, or (`flush` or `end_req`) with `nxt_cnt != 0`.
- On emit:
  - `dct_buffer <= nxt`, `dct_count <= nxt_cnt`, `dct_valid <= 1`.
  - `emit_count` increments.
  - `acc` and `acc_cnt` clear to 0.
- Otherwise: `acc <= nxt`, `acc_cnt <= nxt_cnt`, `dct_valid <= 0`. `dct_buffer` and `dct_count` hold their last emitted value.
- A fragment arriving in the same cycle as `flush` or `end_req` is included in the emitted word.
- `flush` with `nxt_cnt == 0` produces no emit and no strobe.
- State machine:
  - RUN:
    - `end_req` performs the flush described above and moves to ENDING.
    - `flush` alone does not change state.
  - ENDING:
    - `test_ending` is driven 1 for exactly this one cycle.
    - Moves unconditionally to ENDED.
  - ENDED:
    - `test_has_ended` is 1.
    - Stays in ENDED until `reset`.
- In ENDING or ENDED:
  - `frag_valid` sets `frag_dropped`; the fragment is discarded.
  - `flush` and `end_req` are ignored.
  - `dct_valid` stays 0.
- `emit_count` wraps from all-ones to 0.
- Reset, including mid-accumulation or mid-end-sequence:
  - Next state is RUN.
  - `acc`, `acc_cnt`, `dct_buffer`, `dct_count`, `dct_valid`, `test_ending`, `test_has_ended`, `frag_dropped` and `emit_count` all go to 0.
  - Any partial buffer is discarded without an emit.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- `dct_valid` asserts in the cycle after the edge at which the completing fragment, `flush` or `end_req` was sampled. Latency is 1 cycle.
- Back-to-back emits are allowed on consecutive cycles, for example `flush` held high while a fragment arrives every cycle.
- After the 15th fragment, a fragment on the next cycle starts a new word with `acc_cnt = 1`. No fragment is lost.
- `end_req` sampled at edge N:
  - Final `dct_valid` (if any) is high after edge N.
  - `test_ending` is high after edge N+1 for one cycle.
  - `test_has_ended` is high from edge N+2 onward.
- The final `dct_valid` therefore precedes `test_ending` by exactly one cycle.
- `frag_dropped` rises the cycle after the first dropped fragment.

## Test plan

- 15 consecutive fragments with `frag_data = k mod 4` (k = 0..14) -> one `dct_valid` with `dct_count = 15`, `dct_buffer = 0x24E4E4E4`, `emit_count = 1`.
- 3 fragments (1, 2, 3), then `flush` alone -> `dct_count = 3`, `dct_buffer = 0x00000039`. A second `flush` with an empty buffer produces no strobe.
- 16 fragments on consecutive cycles -> `dct_valid` for a word with `dct_count = 15`; the 16th fragment is held with `acc_cnt = 1`. A following `flush` emits `dct_count = 1`.
- 5 fragments of value 3, with `end_req` and a 6th fragment in the same cycle:
  - `dct_count = 6`, `dct_buffer = 0x00000FFF`;
  - `test_ending` high one cycle later, for one cycle;
  - `test_has_ended` latched high after that.
  - A fragment sent in ENDED sets `frag_dropped = 1`, and `dct_valid` stays 0.
- `reset` asserted with `acc_cnt = 7`, then released, then 15 fragments -> no emit from the stale 7 fragments; first emit has `dct_count = 15`; `emit_count = 1`.
- `reset` asserted in ENDED -> all outputs 0 and state RUN next cycle; normal packing resumes.
